// File: rtl/scroll_seg_driver.sv
// Multiplexed seven-segment driver that shows a DIGITS-wide window of a
// writable hex message buffer and scrolls that window at a programmable rate.
module scroll_seg_driver #(
    parameter int DIGITS        = 4,
    parameter int MSG_LEN       = 21,
    parameter int SCAN_CYCLES   = 32768,
    parameter int SCROLL_CYCLES = 33554432,
    parameter int AW            = $clog2(MSG_LEN),
    parameter int LW            = $clog2(MSG_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [3:0]        wr_data,
    input  logic [LW-1:0]     msg_len,
    input  logic              scroll_en,
    input  logic              dir,
    output logic [DIGITS-1:0] grounds,
    output logic [6:0]        display,
    output logic [AW-1:0]     pos,
    output logic              wrap
);
    localparam int DW  = $clog2(DIGITS);
    localparam int SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int SRW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
    localparam int SW  = LW + 1;

    logic [3:0]        r_buf [MSG_LEN];
    logic [SCW-1:0]    r_scan;
    logic [SRW-1:0]    r_scroll;
    logic [DW-1:0]     r_digit;
    logic [DIGITS-1:0] r_grounds;
    logic [6:0]        r_display;
    logic [AW-1:0]     r_pos;
    logic              r_wrap;
    logic              r_first;

    logic              w_scan_tick;
    logic [DW-1:0]     w_digit_next;
    logic [DW-1:0]     w_disp_digit;
    logic [SW-1:0]     w_idx;
    logic              w_visible;
    logic [3:0]        w_nibble;
    logic [6:0]        w_seg;
    logic              w_long;
    logic [LW-1:0]     w_last;
    logic [LW-1:0]     w_pos_ext;
    logic              w_scroll_tc;
    logic              w_step;
    logic              w_wr_ok;
    logic [AW-1:0]     w_pos_next;
    logic              w_wrap_next;
    logic [SRW-1:0]    w_scroll_next;

    // Active-high a..g pattern; inverted once at the output mux.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h7E;  4'h1: g = 7'h30;  4'h2: g = 7'h6D;  4'h3: g = 7'h79;
            4'h4: g = 7'h33;  4'h5: g = 7'h5B;  4'h6: g = 7'h5F;  4'h7: g = 7'h70;
            4'h8: g = 7'h7F;  4'h9: g = 7'h7B;  4'hA: g = 7'h77;  4'hB: g = 7'h1F;
            4'hC: g = 7'h4E;  4'hD: g = 7'h3D;  4'hE: g = 7'h4F;  default: g = 7'h47;
        endcase
        return g;
    endfunction

    assign w_scan_tick  = (r_scan == SCW'(SCAN_CYCLES - 1));
    assign w_digit_next = (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + DW'(1);
    assign w_disp_digit = w_scan_tick ? w_digit_next : r_digit;

    // Segment content for the digit that becomes active on this edge.
    assign w_idx     = SW'(r_pos) + SW'(w_disp_digit);
    assign w_visible = (w_idx < SW'(msg_len));
    assign w_nibble  = r_buf[w_idx[AW-1:0]];
    assign w_seg     = w_visible ? ~glyph(w_nibble) : 7'h7F;

    assign w_long      = (msg_len > LW'(DIGITS));
    assign w_last      = w_long ? (msg_len - LW'(DIGITS)) : '0;
    assign w_pos_ext   = LW'(r_pos);
    assign w_scroll_tc = (r_scroll == SRW'(SCROLL_CYCLES - 1));
    assign w_step      = w_long && scroll_en && w_scroll_tc;
    assign w_wr_ok     = wr_en && ({1'b0, wr_addr} < (AW + 1)'(MSG_LEN));

    always_comb begin
        w_scroll_next = r_scroll;
        if (!w_long)
            w_scroll_next = '0;
        else if (scroll_en)
            w_scroll_next = w_scroll_tc ? '0 : r_scroll + SRW'(1);
    end

    // A window left past the end by a shrinking msg_len snaps home silently.
    always_comb begin
        w_pos_next  = r_pos;
        w_wrap_next = 1'b0;
        if (!w_long || (w_pos_ext > w_last)) begin
            w_pos_next = '0;
        end else if (w_step) begin
            if (!dir) begin
                if (w_pos_ext >= w_last) begin
                    w_pos_next  = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_pos_next = r_pos + AW'(1);
                end
            end else begin
                if (r_pos == '0) begin
                    w_pos_next  = AW'(w_last);
                    w_wrap_next = 1'b1;
                end else begin
                    w_pos_next = r_pos - AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan    <= '0;
            r_digit   <= '0;
            r_grounds <= DIGITS'(1);
            r_display <= 7'h7F;
            r_first   <= 1'b1;
        end else begin
            r_first <= 1'b0;
            r_scan  <= w_scan_tick ? '0 : r_scan + SCW'(1);
            if (w_scan_tick) begin
                r_digit   <= w_digit_next;
                r_grounds <= {r_grounds[DIGITS-2:0], r_grounds[DIGITS-1]};
            end
            if (w_scan_tick || r_first)
                r_display <= w_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scroll <= '0;
            r_pos    <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_scroll <= w_scroll_next;
            r_pos    <= w_pos_next;
            r_wrap   <= w_wrap_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++)
                r_buf[i] <= 4'h0;
        end else if (w_wr_ok) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    assign grounds = r_grounds;
    assign display = r_display;
    assign pos     = r_pos;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_scroll_seg_driver.sv
// Randomized bench for scroll_seg_driver against a cycle-level behavioural
// model of the display window, scan rotation and scroll stepping.
module tb_scroll_seg_driver;
    localparam int D   = 4;
    localparam int ML  = 21;
    localparam int SC  = 4;
    localparam int SRC = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;
    logic [4:0] msg_len;
    logic       scroll_en;
    logic       dir;
    logic [3:0] grounds;
    logic [6:0] display;
    logic [4:0] pos;
    logic       wrap;

    scroll_seg_driver #(
        .DIGITS(D), .MSG_LEN(ML), .SCAN_CYCLES(SC), .SCROLL_CYCLES(SRC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .msg_len(msg_len), .scroll_en(scroll_en), .dir(dir),
        .grounds(grounds), .display(display), .pos(pos), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state
    int         m_buf [ML];
    int         m_scan, m_digit, m_pos, m_scroll;
    bit         m_wrap, m_first;
    logic [6:0] m_disp;
    int         wrap_cnt;

    localparam logic [6:0] GLY [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
        7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_for(input int idx);
        if (idx >= int'(msg_len)) return 7'h7F;
        return ~GLY[m_buf[idx]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ML; i++) m_buf[i] = 0;
        m_scan = 0; m_digit = 0; m_pos = 0; m_scroll = 0;
        m_wrap = 0; m_first = 1; m_disp = 7'h7F;
    endtask

    // Advance the model by one clock using the inputs visible at this edge.
    task automatic model_step();
        bit tick, step;
        int len, last;
        len  = int'(msg_len);
        tick = (m_scan == SC - 1);
        m_scan = tick ? 0 : m_scan + 1;
        if (tick) m_digit = (m_digit + 1) % D;
        if (tick || m_first) m_disp = seg_for(m_pos + m_digit);
        m_first = 0;
        m_wrap  = 0;
        if (len <= D) begin
            m_pos = 0; m_scroll = 0;
        end else begin
            last = len - D;
            step = 0;
            if (scroll_en) begin
                if (m_scroll == SRC - 1) begin m_scroll = 0; step = 1; end
                else m_scroll++;
            end
            if (m_pos > last) m_pos = 0;
            else if (step) begin
                if (!dir) begin
                    if (m_pos >= last) begin m_pos = 0; m_wrap = 1; end
                    else m_pos++;
                end else begin
                    if (m_pos == 0) begin m_pos = last; m_wrap = 1; end
                    else m_pos--;
                end
            end
        end
        if (wr_en && int'(wr_addr) < ML) m_buf[wr_addr] = int'(wr_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_val("grounds", grounds, 32'(1) << m_digit);
        check_val("display", display, m_disp);
        check_val("pos", pos, m_pos);
        check_val("wrap", wrap, m_wrap);
        if (wrap) wrap_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Assert reset between edges, verify asynchronous clear, release on a negedge.
    task automatic do_reset(input int dly);
        #(dly);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_grounds", grounds, 1);
        check_val("rst_pos", pos, 0);
        check_val("rst_wrap", wrap, 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_hold_grounds", grounds, 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int msg[8] = '{1, 5, 0, 1, 1, 6, 0, 6};
        int s_held, waited;
        bit seen;

        rst_n = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
        msg_len = 5'd8; scroll_en = 0; dir = 0;
        model_reset();
        @(posedge clk); #1;
        do_reset(0);

        // 1: load message, frozen window
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_data = 4'(msg[i]);
            tick();
        end
        wr_en = 0;
        run(40);
        check_val("p1_pos", pos, 0);
        $display("phase 1: frozen scan, checks=%0d errors=%0d", n_checks, n_err);

        // 2: scroll left through a full loop
        scroll_en = 1; dir = 0; wrap_cnt = 0;
        run(64);
        check_val("p2_pos1", pos, 1);
        run(256);
        check_val("p2_pos_wrapped", pos, 0);
        check_val("p2_wrap_count", wrap_cnt, 1);
        $display("phase 2: scroll left, checks=%0d errors=%0d", n_checks, n_err);

        // 3: reverse direction
        dir = 1;
        run(64);
        check_val("p3_pos4", pos, 4);
        run(64);
        check_val("p3_pos3", pos, 3);
        $display("phase 3: scroll right, checks=%0d errors=%0d", n_checks, n_err);

        // 4: short message never scrolls
        msg_len = 5'd3; wrap_cnt = 0;
        run(200);
        check_val("p4_pos", pos, 0);
        check_val("p4_wrap_count", wrap_cnt, 0);
        $display("phase 4: short message, checks=%0d errors=%0d", n_checks, n_err);

        // 5: shrink past window, then pause/resume of the scroll counter
        msg_len = 5'd8; dir = 0;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (pos == 5'd4) seen = 1;
        end
        check_val("p5_reach_pos4", pos, 4);
        msg_len = 5'd6; wrap_cnt = 0;
        tick();
        check_val("p5_clamp_pos", pos, 0);
        check_val("p5_clamp_wrap", wrap_cnt, 0);
        scroll_en = 0;
        run(100);
        s_held = m_scroll;
        scroll_en = 1;
        waited = 0; seen = 0;
        for (int i = 0; i < 2 * SRC && !seen; i++) begin
            tick();
            waited++;
            if (pos != 5'd0) seen = 1;
        end
        check_val("p5_resume_latency", waited, SRC - s_held);
        $display("phase 5: clamp and resume, checks=%0d errors=%0d", n_checks, n_err);

        // 6: randomized traffic
        for (int i = 0; i < 1500; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 3) msg_len = 5'($urandom_range(0, ML));
            if ($urandom_range(0, 99) < 2) dir = ~dir;
            if ($urandom_range(0, 99) < 3) scroll_en = ($urandom_range(0, 9) != 0);
            tick();
        end
        wr_en = 0;
        $display("phase 6: random traffic, checks=%0d errors=%0d", n_checks, n_err);

        // 7: reset mid-scroll at a random phase
        msg_len = 5'd12; scroll_en = 1;
        run($urandom_range(1, 200));
        do_reset($urandom_range(1, 3));
        msg_len = 5'd8; scroll_en = 0;
        run(20);
        check_val("p7_display_zero", display, 7'h01);
        check_val("p7_pos", pos, 0);
        $display("phase 7: async reset, checks=%0d errors=%0d", n_checks, n_err);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/scroll_seg_driver.md
Name: scroll_seg_driver

Overview:
Parametrised multiplexed seven-segment driver with a writable message buffer and a hardware scroller. It shows a DIGITS-wide window of a hex message up to MSG_LEN nibbles, which replaces hard-coded digit tables. The window moves left or right at a programmable rate, and a pulse marks each wrap. It sits between the board's common-ground digit enables and the segment lines.

Parameters:
DIGITS, 4, number of multiplexed digits (>=2)
MSG_LEN, 21, message buffer depth in nibbles (>=DIGITS)
SCAN_CYCLES, 32768, clk cycles each digit stays enabled
SCROLL_CYCLES, 33554432, clk cycles per scroll step
AW, clog2(MSG_LEN), buffer address width
LW, clog2(MSG_LEN+1), length field width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write one nibble into the buffer this cycle
wr_addr  in  AW  write address; writes with wr_addr>=MSG_LEN are ignored
wr_data  in  4  nibble to write
msg_len  in  LW  active message length in nibbles (0..MSG_LEN)
scroll_en  in  1  1 = scroll enabled, 0 = window frozen
dir  in  1  0 = window start increments (text moves left), 1 = start decrements
grounds  out  DIGITS  one-hot digit enable, active-high; bit d selects digit d
display  out  7  segments a..g, bit6=a, bit0=g, active-low
pos  out  AW  current window start index
wrap  out  1  single-cycle pulse when pos wraps

Behaviour:
- Reset (async assert, sync release): grounds=1 (digit 0), pos=0, wrap=0, scan and scroll counters=0, all buffer entries=0. display shows the glyph for buffer[0] if msg_len>0 at the first clock after release; otherwise it is blank (7'h7F).
- Scan counter counts 0..SCAN_CYCLES-1 continuously. At the terminal count, grounds rotates left (bit DIGITS-1 -> bit0) and the digit index advances modulo DIGITS.
- display is registered and loads on the same edge as grounds, so both change together (no ghosting). Content is the glyph of buffer[pos+d] for the newly selected digit d. If pos+d>=msg_len, the digit is blank (7'h7F).
- Glyphs (active-high a..g, inverted at output): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
- Last start index L = msg_len-DIGITS.
- Scroll counter advances only while scroll_en=1 and msg_len>DIGITS. It holds its value (no clear) when scroll_en=0. At the terminal count SCROLL_CYCLES-1 it returns to 0 and pos steps:
  - dir=0: if pos>=L, then pos=0 and wrap=1; else pos+1.
  - dir=1: if pos==0, then pos=L and wrap=1; else pos-1.
- wrap is 0 on all other cycles.
- msg_len<=DIGITS: pos is forced to 0, the scroll counter is held at 0, there are no wrap pulses, and unused digits are blank.
- msg_len changed so that pos>L: pos loads 0 on the next clock with no wrap pulse. The scroll counter keeps its value.
- Write path: a write lands in the buffer on the clock edge. A write to a currently visible nibble appears at that digit's next scan slot. A write and scroll step on the same edge is legal. The step uses the old pos, and display content is drawn from the post-write buffer at later scan ticks.
- dir changed mid-run: takes effect at the next scroll step. No extra pulse is produced.
- Reset mid-operation restores every reset value above, including clearing the buffer.

Test Plan:
(Bench params: DIGITS=4, MSG_LEN=21, SCAN_CYCLES=4, SCROLL_CYCLES=64.)
1. Reset, then load 1,5,0,1,1,6,0,6 with msg_len=8 and scroll_en=0 -> grounds cycles 1,2,4,8,1 every 4 clocks, with display 7'h4F,7'h24,7'h01,7'h4F, paired with each enable (glyph 1 on digit 0). pos stays at 0.
2. Same load, scroll_en=1, dir=0 -> pos goes 1,2,3,4 every 64 clocks. At the step from pos=4 it wraps to 0 with exactly one wrap pulse. Digit0 at pos=1 shows 5 (7'h24).
3. dir=1 from pos=0 -> next step gives pos=4 with a wrap pulse, then 3.
4. msg_len=3 -> digit3 is blank (7'h7F). pos stays 0 and wrap never pulses even with scroll_en=1.
5. With pos=4, drop msg_len to 6 -> pos=0 next clock, no wrap. Also: scroll_en=0 for 100 clocks, then re-enable -> the step arrives after the remaining count only, not a full 64 clocks.
6. Assert rst_n low mid-scroll at a random phase -> grounds=1, pos=0, wrap=0 immediately, without a clock. After release, all digits read 0 (7'h01).
